// File: rtl/zbb_issue_stage.sv
// zbb_issue_stage: two-stage valid/ready pipeline around the combinational ZBB datapath.
// Define ZBB_ISSUE_SKID_EN to add a 1-entry skid buffer in front of S1 (registered InReady).
module zbb_issue_stage #(
   parameter int WIDTH = 32,
   parameter int TAGW  = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             Flush,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] InA,
   input  logic [WIDTH-1:0] InB,
   input  logic             InW64,
   input  logic             InBUnsigned,
   input  logic [2:0]       InZBBSelect,
   input  logic [TAGW-1:0]  InTag,
   output logic [WIDTH-1:0] ZA,
   output logic [WIDTH-1:0] ZRevA,
   output logic [WIDTH-1:0] ZB,
   output logic             ZW64,
   output logic             ZLT,
   output logic             ZLTU,
   output logic             ZBUnsigned,
   output logic [2:0]       ZZBBSelect,
   input  logic [WIDTH-1:0] ZBBResult,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] OutResult,
   output logic [TAGW-1:0]  OutTag,
   output logic [15:0]      OpCount
);
   logic            v1, adv2, ld1;
   logic [TAGW-1:0] tag1;
   logic [WIDTH-1:0] na, nb;
   logic            nw, nu;
   logic [2:0]      ns;
   logic [TAGW-1:0] nt;
   assign adv2 = v1 & (~OutValid | OutReady);
`ifdef ZBB_ISSUE_SKID_EN
   logic            sv, sw, su, free;
   logic [WIDTH-1:0] sa, sb;
   logic [2:0]      ss;
   logic [TAGW-1:0] st;
   assign free    = ~v1 | adv2;
   assign InReady = ~sv;
   assign ld1     = (sv | InValid) & free;
   // a parked op always enters S1 ahead of anything new on the input
   assign {na, nb, nw, nu, ns, nt} = sv ? {sa, sb, sw, su, ss, st}
                                        : {InA, InB, InW64, InBUnsigned, InZBBSelect, InTag};
   always_ff @(posedge clk) begin
      if (!reset_n || Flush) sv <= 1'b0;
      else if (sv) sv <= ~free;
      else if (InValid && !free) begin
         sv <= 1'b1;
         {sa, sb, sw, su, ss, st} <= {InA, InB, InW64, InBUnsigned, InZBBSelect, InTag};
      end
   end
`else
   assign InReady = ~v1 | adv2;
   assign ld1     = InValid & InReady;
   assign {na, nb, nw, nu, ns, nt} = {InA, InB, InW64, InBUnsigned, InZBBSelect, InTag};
`endif
   genvar i;
   for (i = 0; i < WIDTH; i++) begin : g_rev
      assign ZRevA[i] = ZA[WIDTH-1-i];
   end
   assign ZLT  = $signed(ZA) < $signed(ZB);
   assign ZLTU = ZA < ZB;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         v1         <= 1'b0;
         ZA         <= '0;
         ZB         <= '0;
         ZW64       <= 1'b0;
         ZBUnsigned <= 1'b0;
         ZZBBSelect <= '0;
         tag1       <= '0;
      end else begin
         v1 <= ~Flush & (ld1 | (v1 & ~adv2));
         if (ld1 && !Flush) {ZA, ZB, ZW64, ZBUnsigned, ZZBBSelect, tag1} <= {na, nb, nw, nu, ns, nt};
      end
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         OutValid  <= 1'b0;
         OutResult <= '0;
         OutTag    <= '0;
         OpCount   <= '0;
      end else begin
         OutValid <= ~Flush & (adv2 | (OutValid & ~OutReady));
         if (adv2 && !Flush) {OutResult, OutTag} <= {ZBBResult, tag1};
         OpCount <= OpCount + {15'd0, OutValid & OutReady};
      end
   end
endmodule

// File: tb/tb_zbb_issue_stage.sv
// tb_zbb_issue_stage: random and directed stimulus, scoreboard against a reference ZBB model.
module tb_zbb_issue_stage;
   localparam int W = 32, T = 5;
`ifdef ZBB_ISSUE_SKID_EN
   localparam int EXP_ACC = 3;
`else
   localparam int EXP_ACC = 2;
`endif
   typedef struct { logic [W-1:0] res; logic [T-1:0] tag; } exp_t;
   logic clk = 0, reset_n = 0, Flush = 0, InValid = 0, InW64 = 0, InBUnsigned = 0, OutReady = 0;
   logic [W-1:0] InA = 0, InB = 0;
   logic [2:0] InZBBSelect = 0;
   logic [T-1:0] InTag = 0;
   logic InReady, ZW64, ZLT, ZLTU, ZBUnsigned, OutValid;
   logic [W-1:0] ZA, ZRevA, ZB, ZBBResult, OutResult;
   logic [2:0] ZZBBSelect;
   logic [T-1:0] OutTag;
   logic [15:0] OpCount, exp_cnt = 0;
   int tests = 0, fails = 0;
   exp_t q[$];

   zbb_issue_stage #(.WIDTH(W), .TAGW(T)) dut (
      .clk(clk), .reset_n(reset_n), .Flush(Flush), .InValid(InValid), .InReady(InReady),
      .InA(InA), .InB(InB), .InW64(InW64), .InBUnsigned(InBUnsigned), .InZBBSelect(InZBBSelect),
      .InTag(InTag), .ZA(ZA), .ZRevA(ZRevA), .ZB(ZB), .ZW64(ZW64), .ZLT(ZLT), .ZLTU(ZLTU),
      .ZBUnsigned(ZBUnsigned), .ZZBBSelect(ZZBBSelect), .ZBBResult(ZBBResult),
      .OutValid(OutValid), .OutReady(OutReady), .OutResult(OutResult), .OutTag(OutTag),
      .OpCount(OpCount));

   always #5 clk = ~clk;

   function automatic logic [W-1:0] low_set(input logic [W-1:0] x);
      int n = W;
      for (int k = W - 1; k >= 0; k--) if (x[k]) n = k;
      return W'(n);
   endfunction

   // the ZBB datapath the stage feeds, built only from the Z* outputs
   always_comb begin
      ZBBResult = '0;
      case (ZZBBSelect)
         3'd0: ZBBResult = low_set(ZRevA);
         3'd1: ZBBResult = low_set(ZA);
         3'd2: ZBBResult = W'($countones(ZA));
         3'd3: ZBBResult = (ZBUnsigned ? ZLTU : ZLT) ? ZA : ZB;
         3'd4: ZBBResult = (ZBUnsigned ? ZLTU : ZLT) ? ZB : ZA;
         3'd5: ZBBResult = ZRevA;
         3'd6: ZBBResult = ZW64 ? ZB : ZA;
         default: ZBBResult = {30'd0, ZLT, ZLTU};
      endcase
   end

   function automatic logic [W-1:0] ref_res(input logic [W-1:0] a, b, input logic bu, w, input logic [2:0] sel);
      logic [W-1:0] r = '0;
      int n = 0;
      bit done = 0;
      bit lt = bu ? (a < b) : ($signed(a) < $signed(b));
      case (sel)
         3'd0: begin
            for (int k = 0; k < W; k++) if (!done && a[W-1-k] == 1'b0) n++; else done = 1;
            r = W'(n);
         end
         3'd1: begin
            if (a == 0) n = W;
            else while (((a >> n) & 1) == 0) n++;
            r = W'(n);
         end
         3'd2: begin
            for (int k = 0; k < W; k++) n += int'(a[k]);
            r = W'(n);
         end
         3'd3: r = lt ? a : b;
         3'd4: r = lt ? b : a;
         3'd5: for (int k = 0; k < W; k++) r[k] = a[W-1-k];
         3'd6: r = w ? b : a;
         default: r = {30'd0, $signed(a) < $signed(b), a < b};
      endcase
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: sees the cycle's handshakes before the coming edge acts on them
   always @(negedge clk) begin
      exp_t e;
      chk("opcount", {48'd0, OpCount}, {48'd0, exp_cnt});
      if (OutValid && q.size() == 0) chk("spurious_valid", {63'd0, OutValid}, 64'd0);
      if (!reset_n) begin
         q.delete();
         exp_cnt = 0;
      end else begin
         if (OutValid && OutReady && q.size() > 0) begin
            e = q.pop_front();
            chk("result", {32'd0, OutResult}, {32'd0, e.res});
            chk("tag", {59'd0, OutTag}, {59'd0, e.tag});
            exp_cnt = exp_cnt + 16'd1;
         end
         if (Flush) q.delete();
         else if (InValid && InReady) begin
            e.res = ref_res(InA, InB, InBUnsigned, InW64, InZBBSelect);
            e.tag = InTag;
            q.push_back(e);
         end
      end
   end

   task automatic set_in(input logic [W-1:0] a, b, input logic bu, w, input logic [2:0] sel, input logic [T-1:0] tag);
      {InA, InB, InBUnsigned, InW64, InZBBSelect, InTag} = {a, b, bu, w, sel, tag};
   endtask

   task automatic set_rand(input logic [T-1:0] tag);
      logic [W-1:0] a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 >> $urandom_range(0, 31) : $urandom;
      logic [W-1:0] b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      set_in(a, b, 1'($urandom), 1'($urandom), 3'($urandom), tag);
   endtask

   task automatic send(input logic [W-1:0] a, b, input logic bu, input logic [2:0] sel, input logic [T-1:0] tag);
      int n = 0;
      set_in(a, b, bu, 1'b0, sel, tag);
      InValid = 1;
      forever begin
         @(negedge clk);
         if (InReady) break;
         if (++n > 50) begin
            tests++; fails++;
            $display("FAIL send_timeout: InReady stayed 0 for %0d cycles", n);
            break;
         end
      end
      @(posedge clk); #1 InValid = 0;
   endtask

   initial begin
      int acc_n, n;
      logic [15:0] c0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outvalid", {63'd0, OutValid}, 0);
      chk("rst_outresult", {32'd0, OutResult}, 0);
      chk("rst_outtag", {59'd0, OutTag}, 0);
      chk("rst_z", {ZA, ZB}, 0);
      chk("rst_zflags", {ZRevA, 25'd0, ZW64, ZLT, ZLTU, ZBUnsigned, ZZBBSelect}, 0);
      chk("rst_inready", {63'd0, InReady}, 1);
      reset_n = 1;
      OutReady = 1;
      // clz with latency check
      set_in(32'h0000_0F00, 0, 0, 0, 3'b000, 5'd7);
      InValid = 1;
      @(posedge clk); #1 InValid = 0;
      chk("lat_cycle1", {63'd0, OutValid}, 0);
      @(posedge clk); #1;
      chk("lat_cycle2", {63'd0, OutValid}, 1);
      chk("clz_result", {32'd0, OutResult}, 20);
      chk("clz_tag", {59'd0, OutTag}, 7);
      // signed/unsigned flags at the MSB boundary
      send(32'h8000_0000, 0, 0, 3'b111, 5'd1);
      chk("zlt", {63'd0, ZLT}, 1);
      chk("zltu", {63'd0, ZLTU}, 0);
      chk("zreva", {32'd0, ZRevA}, 64'h1);
      send(32'hFFFF_FFFF, 1, 0, 3'b011, 5'd2);
      send(32'hFFFF_FFFF, 1, 1, 3'b011, 5'd3);
      repeat (4) @(posedge clk);
      // backpressure with four back-to-back ops
      #1 OutReady = 0;
      c0 = exp_cnt;
      acc_n = 0;
      set_rand(5'd10);
      InValid = 1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (InReady) acc_n++;
         @(posedge clk); #1;
         InValid = acc_n < 4;
         if (acc_n < 4) set_rand(5'(10 + acc_n));
      end
      chk("bp_accepts", 64'(acc_n), 64'(EXP_ACC));
      OutReady = 1;
      n = 0;
      while (acc_n < 4 && n < 50) begin
         @(negedge clk);
         if (InReady) acc_n++;
         @(posedge clk); #1;
         InValid = acc_n < 4;
         if (acc_n < 4) set_rand(5'(10 + acc_n));
         n++;
      end
      repeat (6) @(posedge clk);
      #1 chk("bp_opcount", {48'd0, OpCount}, {48'd0, 16'(c0 + 16'd4)});
      // flush with both stages full
      OutReady = 0;
      send(32'h1234, 32'h5678, 0, 3'b010, 5'd20);
      send(32'h0F0F, 32'h1, 0, 3'b001, 5'd21);
      c0 = exp_cnt;
      Flush = 1;
      set_rand(5'd22);
      InValid = 1;
      @(posedge clk); #1;
      Flush = 0;
      InValid = 0;
      chk("flush_outvalid", {63'd0, OutValid}, 0);
      OutReady = 1;
      repeat (3) @(posedge clk);
      #1 chk("flush_opcount", {48'd0, OpCount}, {48'd0, c0});
      send(32'h00FF_0000, 0, 0, 3'b000, 5'd23);
      repeat (4) @(posedge clk);
      // reset in the middle of traffic
      #1 OutReady = 0;
      send(32'hDEAD_BEEF, 32'h1, 0, 3'b101, 5'd24);
      send(32'hCAFE_0001, 32'h2, 1, 3'b100, 5'd25);
      reset_n = 0;
      InValid = 1;
      @(posedge clk); #1;
      chk("midrst_out", {OutResult, 26'd0, OutTag, OutValid}, 0);
      chk("midrst_z", {ZA, ZB}, 0);
      chk("midrst_cnt", {48'd0, OpCount}, 0);
      reset_n = 1;
      InValid = 0;
      chk("midrst_inready", {63'd0, InReady}, 1);
      // randomized traffic with occasional flushes
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         InValid = $urandom_range(0, 3) != 0;
         OutReady = $urandom_range(0, 3) != 0;
         Flush = $urandom_range(0, 39) == 0;
         set_rand(5'($urandom));
      end
      Flush = 0;
      OutReady = 1;
      // run until the completed-op counter wraps
      n = 0;
      while (n < 70000) begin
         @(posedge clk); #1;
         InValid = 1;
         set_rand(5'($urandom));
         n++;
         if (exp_cnt == 16'h0000 && n > 4) break;
      end
      chk("wrap_opcount", {48'd0, OpCount}, 0);
      InValid = 0;
      repeat (6) @(posedge clk);
      #1 chk("drain_empty", 64'(q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
